// File: rtl/thread_sched.sv
// Round-robin issue scheduler for the four-thread pipeline: one PC per thread,
// control-transfer blocking, and a configuration port for start addresses.
module thread_sched #(
  parameter int PC_WIDTH    = 9,
  parameter int NUM_THREADS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          thread_en,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_tid,
  input  logic [PC_WIDTH-1:0] cfg_pc,
  input  logic                stall,
  input  logic                block_set,
  input  logic [1:0]          block_tid,
  input  logic                redirect_valid,
  input  logic [1:0]          redirect_tid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                resolve_valid,
  input  logic [1:0]          resolve_tid,
  output logic                issue_valid,
  output logic [1:0]          issue_tid,
  output logic [PC_WIDTH-1:0] issue_pc,
  output logic [3:0]          blocked,
  output logic                idle
);

  logic [PC_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [3:0]          blocked_q, blocked_d;
  logic [1:0]          last_tid_q, last_tid_d;
  logic                issue_valid_q, issue_valid_d;
  logic [1:0]          issue_tid_q, issue_tid_d;
  logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;

  logic [3:0]          blk_eff;
  logic [3:0]          eligible;
  logic [1:0]          sel;
  logic [1:0]          scan_idx;
  logic                issue_go;

  // A branch decoded this cycle must already keep its thread out of this decision.
  assign blk_eff  = blocked_q | ({3'b000, block_set} << block_tid);
  assign eligible = thread_en & ~blk_eff;
  assign issue_go = !stall && (eligible != 4'b0000);

  // Scan from farthest to nearest so the nearest eligible thread after last_tid wins.
  always_comb begin
    sel      = last_tid_q;
    scan_idx = last_tid_q;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      scan_idx = last_tid_q + 2'(k);
      if (eligible[scan_idx]) begin
        sel = scan_idx;
      end
    end
  end

  always_comb begin
    blocked_d = blocked_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      pc_d[t] = pc_q[t];
      if (issue_go && (sel == 2'(t))) begin
        pc_d[t] = pc_q[t] + PC_WIDTH'(1);
      end
      if (cfg_we && (cfg_tid == 2'(t)) && !thread_en[t]) begin
        pc_d[t]      = cfg_pc;
        blocked_d[t] = 1'b0;
      end
      if (block_set && (block_tid == 2'(t))) begin
        blocked_d[t] = 1'b1;
      end
      if (redirect_valid && (redirect_tid == 2'(t))) begin
        pc_d[t]      = redirect_pc;
        blocked_d[t] = 1'b0;
      end
      if (resolve_valid && (resolve_tid == 2'(t))) begin
        blocked_d[t] = 1'b0;
      end
    end
  end

  // Stall freezes issue state only; side-band updates above still land.
  always_comb begin
    last_tid_d    = last_tid_q;
    issue_valid_d = issue_valid_q;
    issue_tid_d   = issue_tid_q;
    issue_pc_d    = issue_pc_q;
    if (!stall) begin
      issue_valid_d = issue_go;
      if (issue_go) begin
        last_tid_d  = sel;
        issue_tid_d = sel;
        issue_pc_d  = pc_q[sel];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= '0;
      end
      blocked_q     <= '0;
      last_tid_q    <= 2'd3;
      issue_valid_q <= 1'b0;
      issue_tid_q   <= '0;
      issue_pc_q    <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= pc_d[t];
      end
      blocked_q     <= blocked_d;
      last_tid_q    <= last_tid_d;
      issue_valid_q <= issue_valid_d;
      issue_tid_q   <= issue_tid_d;
      issue_pc_q    <= issue_pc_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_tid   = issue_tid_q;
  assign issue_pc    = issue_pc_q;
  assign blocked     = blocked_q;
  assign idle        = (eligible == 4'b0000);

endmodule
